// File: rtl/sockit_str_chk.sv
// -----------------------------------------------------------------------------
// sockit_str_chk -- stream checker with pseudo-random back-pressure
//
// Purpose:
//   Consumes a valid/ready stream and checks that it carries the sequence
//   0, 1, 2, ... (the transfer count, truncated or zero-extended to DW bits).
//   The checker throttles the stream by driving ffo_grt from a 32-bit Galois
//   LFSR compared against a probability threshold. A run starts with a
//   single-cycle start pulse and ends after len transfers. The checker counts
//   completed transfers and data mismatches.
//
// Parameters:
//   DW    stream data width
//   CW    transfer-length / transfer-counter width
//   EW    error-counter width (saturating)
//   SEED  LFSR reset value (0 is mapped to 1, since 0 would lock the LFSR)
//
// Ports:
//   ffo_clk   in   1    clock, rising edge
//   ffo_rst   in   1    synchronous active-high reset
//   ffo_bus   in   DW   stream data
//   ffo_req   in   1    stream request (data valid)
//   ffo_grt   out  1    stream grant (ready), registered
//   prb       in   32   grant probability threshold (grant when lfsr <= prb)
//   len       in   CW   number of transfers to check
//   start     in   1    single-cycle start pulse (ignored while running)
//   busy      out  1    high while a run is in progress
//   done      out  1    high once a run has completed
//   cnt       out  CW   transfers completed in the current/last run
//   err_cnt   out  EW   data mismatches, saturating at all-ones
//   err_flg   out  1    sticky mismatch flag
// -----------------------------------------------------------------------------
module sockit_str_chk #(
    parameter int          DW   = 8,
    parameter int          CW   = 16,
    parameter int          EW   = 16,
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic          ffo_clk,
    input  logic          ffo_rst,
    input  logic [DW-1:0] ffo_bus,
    input  logic          ffo_req,
    output logic          ffo_grt,
    input  logic [31:0]   prb,
    input  logic [CW-1:0] len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt,
    output logic [EW-1:0] err_cnt,
    output logic          err_flg
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1
    localparam logic [31:0] LFSR_INIT = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [EW-1:0] ERR_ZERO = {EW{1'b0}};
    localparam logic [EW-1:0] ERR_ONE  = EW'(1'b1);
    localparam logic [EW-1:0] ERR_MAX  = {EW{1'b1}};

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // One step of the Galois LFSR: shift right, fold the taps back in when the
    // bit shifted out is 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] value);
        logic [31:0] shifted;
        shifted = {1'b0, value[31:1]};
        if (value[0]) begin
            lfsr_step = shifted ^ LFSR_MASK;
        end else begin
            lfsr_step = shifted;
        end
    endfunction

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic          grt_r;
    logic          grt_s;
    logic [31:0]   lfsr_r;
    logic [31:0]   lfsr_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [EW-1:0] err_cnt_r;
    logic [EW-1:0] err_cnt_s;
    logic          err_flg_r;
    logic          err_flg_s;
    logic          busy_r;
    logic          done_r;

    logic          run_s;
    logic          trn_s;
    logic          win_s;
    logic          last_s;
    logic          len_zero_s;
    logic          mism_s;
    logic [DW-1:0] exp_s;

    // -------------------------------------------------------------------------
    // Decoded conditions
    // -------------------------------------------------------------------------
    assign run_s      = (state_r == ST_RUN);
    // Grant is only ever high in RUN, but gate on the state anyway so a
    // transfer can never be counted outside a run.
    assign trn_s      = run_s & ffo_req & grt_r;
    // The LFSR is never zero, so prb == 0 never wins and prb == all-ones
    // always wins.
    assign win_s      = (lfsr_r <= prb);
    assign len_zero_s = (len == CNT_ZERO);
    // Final transfer of the run; compared against the live len input.
    assign last_s     = (cnt_r == (len - CNT_ONE));

    // Expected data is the transfer count, truncated or zero-extended to DW
    generate
        if (DW <= CW) begin : g_exp_trunc
            assign exp_s = cnt_r[DW-1:0];
        end else begin : g_exp_ext
            assign exp_s = {{(DW-CW){1'b0}}, cnt_r};
        end
    endgenerate

    // Case-inequality so that X/Z on the bus counts as a mismatch in simulation
    assign mism_s = (ffo_bus !== exp_s);

    // -------------------------------------------------------------------------
    // Next state and grant
    // -------------------------------------------------------------------------
    // FSM transitions and the registered grant decision.
    always_comb begin
        state_s = state_r;
        grt_s   = grt_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (len_zero_s) begin
                        // Zero-length run completes immediately, no grant
                        state_s = ST_DONE;
                        grt_s   = 1'b0;
                    end else begin
                        // Grant may already be offered in the first RUN cycle
                        state_s = ST_RUN;
                        grt_s   = win_s;
                    end
                end else begin
                    state_s = state_r;
                    grt_s   = 1'b0;
                end
            end
            ST_RUN: begin
                if (trn_s && last_s) begin
                    // Drop grant on the final transfer so nothing more is taken
                    state_s = ST_DONE;
                    grt_s   = 1'b0;
                end else if (!grt_r || trn_s) begin
                    // Re-roll grant when idle or after each accepted transfer
                    state_s = ST_RUN;
                    grt_s   = win_s;
                end else begin
                    // An offered grant is held until the source takes it
                    state_s = ST_RUN;
                    grt_s   = grt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grt_s   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Counters
    // -------------------------------------------------------------------------
    // Transfer counter, saturating error counter and sticky error flag.
    always_comb begin
        cnt_s     = cnt_r;
        err_cnt_s = err_cnt_r;
        err_flg_s = err_flg_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_s     = CNT_ZERO;
                    err_cnt_s = ERR_ZERO;
                    err_flg_s = 1'b0;
                end else begin
                    cnt_s     = cnt_r;
                    err_cnt_s = err_cnt_r;
                    err_flg_s = err_flg_r;
                end
            end
            ST_RUN: begin
                if (trn_s) begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (mism_s) begin
                        err_flg_s = 1'b1;
                        if (err_cnt_r == ERR_MAX) begin
                            err_cnt_s = err_cnt_r;
                        end else begin
                            err_cnt_s = err_cnt_r + ERR_ONE;
                        end
                    end else begin
                        err_flg_s = err_flg_r;
                        err_cnt_s = err_cnt_r;
                    end
                end else begin
                    cnt_s     = cnt_r;
                    err_cnt_s = err_cnt_r;
                    err_flg_s = err_flg_r;
                end
            end
            default: begin
                cnt_s     = CNT_ZERO;
                err_cnt_s = ERR_ZERO;
                err_flg_s = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // LFSR
    // -------------------------------------------------------------------------
    // The LFSR only advances while a run is in progress.
    always_comb begin
        if (run_s) begin
            lfsr_s = lfsr_step(lfsr_r);
        end else begin
            lfsr_s = lfsr_r;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // State, grant, LFSR and counters; reset wins over start and transfers.
    always_ff @(posedge ffo_clk) begin
        if (ffo_rst) begin
            state_r   <= ST_IDLE;
            grt_r     <= 1'b0;
            lfsr_r    <= LFSR_INIT;
            cnt_r     <= CNT_ZERO;
            err_cnt_r <= ERR_ZERO;
            err_flg_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            grt_r     <= grt_s;
            lfsr_r    <= lfsr_s;
            cnt_r     <= cnt_s;
            err_cnt_r <= err_cnt_s;
            err_flg_r <= err_flg_s;
        end
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge ffo_clk) begin
        if (ffo_rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ffo_grt = grt_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign cnt     = cnt_r;
    assign err_cnt = err_cnt_r;
    assign err_flg = err_flg_r;

endmodule

// File: tb/tb_sockit_str_chk.sv
// -----------------------------------------------------------------------------
// tb_sockit_str_chk -- self-checking bench for sockit_str_chk
//
// A behavioural model tracks the run state, the pseudo-random grant, the
// transfer count and the error count with plain integer arithmetic; every
// cycle the DUT outputs are compared against it, and each scenario ends with
// fixed expected values.
// -----------------------------------------------------------------------------
module tb_sockit_str_chk;

    localparam int DW = 8;
    localparam int CW = 16;
    localparam int EW = 16;

    localparam int MS_IDLE = 0;
    localparam int MS_RUN  = 1;
    localparam int MS_DONE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] bus;
    logic          req;
    logic          grt;
    logic [31:0]   prb;
    logic [CW-1:0] len;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;
    logic [EW-1:0] err_cnt;
    logic          err_flg;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int          m_st;
    logic [31:0] m_lfsr;
    bit          m_grt;
    int          m_cnt;
    int          m_err;
    bit          m_flg;

    // Observed longest run of consecutive grant cycles
    int g_run;
    int g_max;

    always #5 clk = ~clk;

    sockit_str_chk #(
        .DW   (DW),
        .CW   (CW),
        .EW   (EW),
        .SEED (32'h0000_0001)
    ) dut (
        .ffo_clk (clk),
        .ffo_rst (rst),
        .ffo_bus (bus),
        .ffo_req (req),
        .ffo_grt (grt),
        .prb     (prb),
        .len     (len),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .cnt     (cnt),
        .err_cnt (err_cnt),
        .err_flg (err_flg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference model by one rising edge using the current inputs
    task automatic model_step();
        bit          trn;
        logic [31:0] cur;
        if (rst) begin
            m_st   = MS_IDLE;
            m_grt  = 1'b0;
            m_cnt  = 0;
            m_err  = 0;
            m_flg  = 1'b0;
            m_lfsr = 32'h0000_0001;
        end else if (m_st != MS_RUN) begin
            m_grt = 1'b0;
            if (start) begin
                m_cnt = 0;
                m_err = 0;
                m_flg = 1'b0;
                if (len != 0) begin
                    m_st  = MS_RUN;
                    m_grt = (m_lfsr <= prb);
                end else begin
                    m_st = MS_DONE;
                end
            end
        end else begin
            trn    = req && m_grt;
            cur    = m_lfsr;
            m_lfsr = (cur >> 1) ^ (cur[0] ? 32'h8020_0003 : 32'h0000_0000);
            if (trn) begin
                if (bus != 8'(m_cnt % 256)) begin
                    m_flg = 1'b1;
                    if (m_err < 65535) m_err++;
                end
                if (m_cnt == int'(len) - 1) begin
                    m_st  = MS_DONE;
                    m_grt = 1'b0;
                end else begin
                    m_grt = (cur <= prb);
                end
                m_cnt++;
            end else if (!m_grt) begin
                m_grt = (cur <= prb);
            end
        end
    endtask

    // One clock: update model, take the edge, compare all outputs after it
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("grt",     32'(grt),     32'(m_grt));
        chk("busy",    32'(busy),    32'(m_st == MS_RUN));
        chk("done",    32'(done),    32'(m_st == MS_DONE));
        chk("cnt",     32'(cnt),     32'(m_cnt));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        chk("err_flg", 32'(err_flg), 32'(m_flg));
        if (grt) g_run++;
        else     g_run = 0;
        if (g_run > g_max) g_max = g_run;
    endtask

    task automatic pulse_start(input logic [CW-1:0] l);
        len   = l;
        start = 1'b1;
        bus   = 8'(m_cnt % 256);
        cycle();
        start = 1'b0;
    endtask

    // Run until the model leaves RUN; corrupt selects transfers to garble,
    // rnd_req randomises the request, rnd_start sprinkles start pulses.
    task automatic run_to_end(input string tag, input int bound, input bit rnd_req,
                              input bit corrupt, input bit rnd_start);
        int k;
        k = 0;
        while (m_st == MS_RUN && k < bound) begin
            if (rnd_req)   req   = 1'($urandom_range(0, 1));
            if (rnd_start) start = ($urandom_range(0, 3) == 0);
            bus = 8'(m_cnt % 256);
            if (corrupt && (m_cnt == 5 || m_cnt == 9)) bus = bus ^ 8'h5A;
            cycle();
            k++;
        end
        start = 1'b0;
        chk({tag, "_bound"}, 32'(k < bound), 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        req   = 1'b0;
        bus   = 8'h00;
        prb   = 32'h0;
        len   = 16'd0;
        g_run = 0;
        g_max = 0;
        cycle();
        cycle();
        chk("rst_grt",  32'(grt),     32'd0);
        chk("rst_busy", 32'(busy),    32'd0);
        chk("rst_done", 32'(done),    32'd0);
        chk("rst_cnt",  32'(cnt),     32'd0);
        chk("rst_err",  32'(err_cnt), 32'd0);
        chk("rst_flg",  32'(err_flg), 32'd0);
        rst = 1'b0;
        cycle();

        // Full-rate run: grant held for 64 consecutive cycles
        prb = 32'hFFFF_FFFF;
        req = 1'b1;
        g_run = 0;
        g_max = 0;
        pulse_start(16'd64);
        chk("t1_lat_busy", 32'(busy), 32'd1);
        chk("t1_lat_grt",  32'(grt),  32'd1);
        run_to_end("t1", 200, 1'b0, 1'b0, 1'b0);
        chk("t1_done", 32'(done),    32'd1);
        chk("t1_cnt",  32'(cnt),     32'd64);
        chk("t1_err",  32'(err_cnt), 32'd0);
        chk("t1_flg",  32'(err_flg), 32'd0);
        chk("t1_grun", 32'(g_max),   32'd64);
        cycle();
        chk("t1_hold_cnt", 32'(cnt), 32'd64);

        // Half probability, random request, data wraps past 8'hFF
        prb = 32'h7FFF_FFFF;
        pulse_start(16'd300);
        run_to_end("t2", 6000, 1'b1, 1'b0, 1'b0);
        chk("t2_done", 32'(done),    32'd1);
        chk("t2_cnt",  32'(cnt),     32'd300);
        chk("t2_err",  32'(err_cnt), 32'd0);
        chk("t2_flg",  32'(err_flg), 32'd0);

        // Corrupted data on transfers 5 and 9
        prb = 32'hFFFF_FFFF;
        req = 1'b1;
        pulse_start(16'd16);
        run_to_end("t3", 200, 1'b0, 1'b1, 1'b0);
        chk("t3_cnt", 32'(cnt),     32'd16);
        chk("t3_err", 32'(err_cnt), 32'd2);
        chk("t3_flg", 32'(err_flg), 32'd1);

        // Zero probability never grants
        prb = 32'h0;
        req = 1'b1;
        pulse_start(16'd4);
        g_run = 0;
        g_max = 0;
        for (int i = 0; i < 100; i++) cycle();
        chk("t4_grun", 32'(g_max), 32'd0);
        chk("t4_busy", 32'(busy),  32'd1);
        chk("t4_cnt",  32'(cnt),   32'd0);

        // Reset mid-run after 10 transfers, then a fresh short run
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        prb = 32'hFFFF_FFFF;
        pulse_start(16'd50);
        for (int k = 0; k < 100 && m_cnt < 10; k++) begin
            bus = 8'(m_cnt % 256);
            cycle();
        end
        chk("t5_pre_cnt", 32'(cnt), 32'd10);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t5_rst_grt",  32'(grt),     32'd0);
        chk("t5_rst_busy", 32'(busy),    32'd0);
        chk("t5_rst_done", 32'(done),    32'd0);
        chk("t5_rst_cnt",  32'(cnt),     32'd0);
        chk("t5_rst_err",  32'(err_cnt), 32'd0);
        chk("t5_rst_flg",  32'(err_flg), 32'd0);
        cycle();
        pulse_start(16'd3);
        run_to_end("t5", 100, 1'b0, 1'b0, 1'b0);
        chk("t5_cnt", 32'(cnt),     32'd3);
        chk("t5_err", 32'(err_cnt), 32'd0);

        // Zero-length start, then start pulses inside a run
        g_run = 0;
        g_max = 0;
        pulse_start(16'd0);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) cycle();
        chk("t6_grun", 32'(g_max), 32'd0);
        pulse_start(16'd20);
        run_to_end("t6", 200, 1'b0, 1'b0, 1'b1);
        chk("t6_cnt",   32'(cnt),  32'd20);
        chk("t6_done2", 32'(done), 32'd1);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
